// File: rtl/ddr3_para_pkg.sv
// Shared definitions for the DDR3 parameter reader.
//   - memory-controller command encodings
//   - default address increment per 128-bit line
//   - reader FSM state encoding
//   - line-count helper (ceil(words/8) without overflow)
package ddr3_para_pkg;

    localparam logic [2:0] CMD_READ       = 3'b001;
    localparam logic [2:0] CMD_WRITE      = 3'b000;

    localparam int         ADDR_STEP_DEF  = 8;
    localparam int         WORDS_PER_LINE = 8;
    localparam int         LINE_W         = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    // The extra top bit keeps num_words = 0xFFFFFFFF from wrapping when 7 is added.
    function automatic logic [32:0] line_count(input logic [31:0] words);
        logic [32:0] sum;
        sum = {1'b0, words} + 33'd7;
        return sum >> 3;
    endfunction

endpackage

// File: rtl/para_line_fifo.sv
// Synchronous FIFO holding 128-bit read lines.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push a line (accepted when not full, or when popping too)
//   rd_en             pop the head line (ignored when empty)
//   rd_data           head line, valid while empty is low
//   count             registered number of stored lines
//   full, empty       registered occupancy flags
module para_line_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 128,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             wr_fire;
    logic             rd_fire;

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // take a write alongside a read.
    assign rd_fire = rd_en && !empty_q;
    assign wr_fire = wr_en && (!full_q || rd_fire);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        count_d = count_q;
        if (wr_fire && !rd_fire) begin
            count_d = count_q + CW'(1);
        end else if (!wr_fire && rd_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (rd_fire) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Line storage carries no reset; occupancy is tracked by the flags above.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/ddr3_para_rd.sv
// Reads a block of 16-bit parameters out of DDR3 and streams them downstream.
// A job reads ceil(num_words/8) 128-bit lines starting at base_addr, buffers
// them in a line FIFO and unpacks each line LSB halfword first.
// Ports:
//   ui_clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, num_words   job request (sampled on start while idle)
//   busy, done                    job status
//   app_rdy, app_cmd_en,
//   app_cmd, app_addr             command channel to the memory controller
//   app_rd_data_valid,
//   app_rd_data                   read data returned by the controller
//   para_valid, para_data,
//   para_ready                    parameter stream to the consumer
module ddr3_para_rd
    import ddr3_para_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = ADDR_STEP_DEF
) (
    input  logic              ui_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       num_words,
    output logic              busy,
    output logic              done,
    input  logic              app_rdy,
    output logic              app_cmd_en,
    output logic [2:0]        app_cmd,
    output logic [32:0]       app_addr,
    input  logic              app_rd_data_valid,
    input  logic [LINE_W-1:0] app_rd_data,
    output logic              para_valid,
    output logic [15:0]       para_data,
    input  logic              para_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       addr_q;
    logic [32:0]       cmds_left_q;
    logic [31:0]       words_left_q;
    logic [2:0]        idx_q;
    logic [CW-1:0]     inflight_q;

    logic [32:0]       lines_d;
    logic [CW:0]       occupancy;
    logic              room;
    logic              cmd_en;
    logic              cmd_acc;
    logic              beat_ok;
    logic              xfer;
    logic              last_word;
    logic              fifo_rd;
    logic [LINE_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign lines_d = line_count(num_words);

    // Lines already requested count against the buffer, so returned data
    // always has a free slot and never needs back-pressure. The sum only
    // grows on an accepted command, which keeps app_cmd_en stable until then.
    assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign room      = (occupancy < (CW + 1)'(FIFO_DEPTH)) && !fifo_full;
    assign cmd_en    = (state_q == ISSUE) && (cmds_left_q != '0) && room;
    assign cmd_acc   = cmd_en && app_rdy;

    // With nothing outstanding (e.g. right after a reset) any beat is stale.
    assign beat_ok   = app_rd_data_valid && (inflight_q != '0);

    assign para_valid = ((state_q == ISSUE) || (state_q == DRAIN)) && !fifo_empty;
    assign xfer       = para_valid && para_ready;
    assign last_word  = (words_left_q == 32'd1);
    // The head line is released after its eighth halfword, or after the job's
    // final word, which discards the unused tail of a partial last line.
    assign fifo_rd    = xfer && ((idx_q == 3'd7) || last_word);
    assign para_data  = fifo_head[{idx_q, 4'b0000} +: 16];

    para_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LINE_W)
    ) u_line_fifo (
        .clk     (ui_clk),
        .rst_n   (rst_n),
        .wr_en   (beat_ok),
        .wr_data (app_rd_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            cmds_left_q  <= '0;
            words_left_q <= '0;
            idx_q        <= '0;
            inflight_q   <= '0;
        end else begin
            done_q <= 1'b0;

            if (cmd_acc && !beat_ok) begin
                inflight_q <= inflight_q + CW'(1);
            end else if (!cmd_acc && beat_ok) begin
                inflight_q <= inflight_q - CW'(1);
            end

            if (cmd_acc) begin
                addr_q      <= addr_q + 32'(ADDR_STEP);
                cmds_left_q <= cmds_left_q - 33'd1;
            end

            if (xfer) begin
                words_left_q <= words_left_q - 32'd1;
                idx_q        <= fifo_rd ? 3'd0 : idx_q + 3'd1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q       <= base_addr;
                        cmds_left_q  <= lines_d;
                        words_left_q <= num_words;
                        idx_q        <= 3'd0;
                        busy_q       <= 1'b1;
                        if (num_words == 32'd0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_acc && (cmds_left_q == 33'd1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer && last_word) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign app_cmd_en = cmd_en;
    assign app_cmd    = CMD_READ;
    assign app_addr   = {1'b0, addr_q};

endmodule

// File: tb/tb_ddr3_para_rd.sv
// Scoreboard bench for ddr3_para_rd: jobs push expected commands and words,
// a memory model answers accepted reads, and a monitor compares handshakes.
module tb_ddr3_para_rd;

    logic         ui_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [31:0]  num_words = '0;
    logic         busy;
    logic         done;
    logic         app_rdy;
    logic         app_cmd_en;
    logic [2:0]   app_cmd;
    logic [32:0]  app_addr;
    logic         app_rd_data_valid;
    logic [127:0] app_rd_data;
    logic         para_valid;
    logic [15:0]  para_data;
    logic         para_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int cmd_cnt = 0;
    int done_cnt = 0;
    int cmd_en_cyc = 0;
    bit rdy_toggle = 1'b0;

    logic [31:0]  exp_cmd[$];
    logic [15:0]  exp_word[$];
    logic [127:0] resp_q[$];
    logic [15:0]  obs[$];

    ddr3_para_rd dut (
        .ui_clk            (ui_clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .num_words         (num_words),
        .busy              (busy),
        .done              (done),
        .app_rdy           (app_rdy),
        .app_cmd_en        (app_cmd_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data       (app_rd_data),
        .para_valid        (para_valid),
        .para_data         (para_data),
        .para_ready        (para_ready)
    );

    initial forever #5 ui_clk = ~ui_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Memory contents: halfword j of the line at address a is {j, a[11:0]}.
    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) r[j*16 +: 16] = {4'(j), a[11:0]};
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic expect_job(input logic [31:0] base, input int n);
        logic [31:0] a;
        int lines;
        lines = (n + 7) / 8;
        for (int i = 0; i < lines; i++) exp_cmd.push_back(base + 32'(i * 8));
        for (int w = 0; w < n; w++) begin
            a = base + 32'((w / 8) * 8);
            exp_word.push_back({4'(w % 8), a[11:0]});
        end
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [31:0] n);
        @(posedge ui_clk); #1;
        base_addr = base;
        num_words = n;
        start = 1'b1;
        @(posedge ui_clk); #1;
        start = 1'b0;
        @(negedge ui_clk);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge ui_clk);
            i++;
        end
        check("done_timeout", done_cnt != d0, 1'b1);
    endtask

    task automatic finish_job(input int d0);
        repeat (3) @(negedge ui_clk);
        check("exp_cmd_left", exp_cmd.size(), 0);
        check("exp_word_left", exp_word.size(), 0);
        check("done_once", done_cnt - d0, 1);
        check("busy_idle", busy, 1'b0);
        check("valid_idle", para_valid, 1'b0);
    endtask

    // app_rdy driver
    initial begin
        app_rdy = 1'b1;
        forever begin
            @(posedge ui_clk); #1;
            app_rdy = rdy_toggle ? ~app_rdy : 1'b1;
        end
    end

    // Memory model: one beat per cycle, one cycle after the command.
    initial begin
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        forever begin
            @(posedge ui_clk); #1;
            if (resp_q.size() > 0) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = resp_q.pop_front();
            end else begin
                app_rd_data_valid = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        bit          hold_pend;
        logic [32:0] hold_addr;
        bit          dhold_pend;
        logic [15:0] dhold_data;
        logic [31:0] e;
        hold_pend = 0;
        dhold_pend = 0;
        forever begin
            @(negedge ui_clk);
            if (!rst_n) begin
                hold_pend = 0;
                dhold_pend = 0;
            end else begin
                if (hold_pend) check("cmd_hold", {app_cmd_en, app_addr}, {1'b1, hold_addr});
                hold_pend = app_cmd_en && !app_rdy;
                hold_addr = app_addr;
                if (app_cmd_en) cmd_en_cyc++;
                if (app_cmd_en && app_rdy) begin
                    cmd_cnt++;
                    if (exp_cmd.size() == 0) begin
                        unexpected("cmd_extra", app_addr);
                    end else begin
                        e = exp_cmd.pop_front();
                        check("cmd_addr", {app_cmd, app_addr}, {3'b001, 1'b0, e});
                    end
                    resp_q.push_back(line_of(app_addr[31:0]));
                end
                if (dhold_pend) check("data_hold", {para_valid, para_data}, {1'b1, dhold_data});
                dhold_pend = para_valid && !para_ready;
                dhold_data = para_data;
                if (para_valid && para_ready) begin
                    obs.push_back(para_data);
                    if (exp_word.size() == 0) unexpected("word_extra", para_data);
                    else check("word", para_data, exp_word.pop_front());
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        int c0;
        int d0;
        int i;

        // Reset state
        repeat (3) @(negedge ui_clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cmd_en", app_cmd_en, 1'b0);
        check("rst_valid", para_valid, 1'b0);
        check("rst_addr", app_addr, 33'h0);
        check("rst_cmd", app_cmd, 3'b001);
        @(posedge ui_clk); #1;
        rst_n = 1'b1;

        // 16 words from 0x100
        obs.delete();
        c0 = cmd_cnt; d0 = done_cnt;
        expect_job(32'h100, 16);
        pulse_start(32'h100, 16);
        wait_done(d0, 500);
        finish_job(d0);
        check("t1_cmds", cmd_cnt - c0, 2);
        check("t1_nwords", obs.size(), 16);
        check("t1_w0", obs[0], 16'h0100);
        check("t1_w7", obs[7], 16'h7100);
        check("t1_w8", obs[8], 16'h0108);
        check("t1_w15", obs[15], 16'h7108);

        // 19 words: partial final line
        obs.delete();
        c0 = cmd_cnt; d0 = done_cnt;
        expect_job(32'h400, 19);
        pulse_start(32'h400, 19);
        wait_done(d0, 500);
        finish_job(d0);
        check("t2_cmds", cmd_cnt - c0, 3);
        check("t2_nwords", obs.size(), 19);
        check("t2_w18", obs[18], 16'h2410);

        // Consumer stalled for 200 cycles
        obs.delete();
        para_ready = 1'b0;
        c0 = cmd_cnt; d0 = done_cnt;
        expect_job(32'h800, 64);
        pulse_start(32'h800, 64);
        repeat (200) @(negedge ui_clk);
        check("t3_cmds_le4", (cmd_cnt - c0) <= 4, 1'b1);
        check("t3_valid", para_valid, 1'b1);
        @(posedge ui_clk); #1;
        para_ready = 1'b1;
        wait_done(d0, 1000);
        finish_job(d0);
        check("t3_cmds", cmd_cnt - c0, 8);
        check("t3_nwords", obs.size(), 64);

        // app_rdy toggling, address wrap past 0xFFFFFFFF
        obs.delete();
        rdy_toggle = 1'b1;
        c0 = cmd_cnt; d0 = done_cnt;
        expect_job(32'hFFFF_FFF0, 40);
        pulse_start(32'hFFFF_FFF0, 40);
        wait_done(d0, 1000);
        finish_job(d0);
        rdy_toggle = 1'b0;
        check("t4_cmds", cmd_cnt - c0, 5);
        check("t4_nwords", obs.size(), 40);
        check("t4_w16", obs[16], 16'h0000);

        // Empty job
        c0 = cmd_en_cyc; d0 = done_cnt;
        pulse_start(32'h300, 0);
        check("t5_done_next", done, 1'b1);
        repeat (4) @(negedge ui_clk);
        check("t5_no_cmd_en", cmd_en_cyc - c0, 0);
        check("t5_done_once", done_cnt - d0, 1);
        check("t5_busy", busy, 1'b0);

        // Reset mid-DRAIN, stale beats, then a fresh 8-word job
        para_ready = 1'b0;
        expect_job(32'h1000, 24);
        pulse_start(32'h1000, 24);
        repeat (10) @(negedge ui_clk);
        @(posedge ui_clk); #1;
        para_ready = 1'b1;
        repeat (3) @(posedge ui_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_valid", para_valid, 1'b0);
        check("t6_rst_cmd_en", app_cmd_en, 1'b0);
        check("t6_rst_addr", app_addr, 33'h0);
        exp_word.delete();
        exp_cmd.delete();
        @(posedge ui_clk); #1;
        rst_n = 1'b1;
        resp_q.push_back(128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
        resp_q.push_back(128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D);
        i = 0;
        while (resp_q.size() > 0 && i < 50) begin
            @(posedge ui_clk);
            i++;
        end
        repeat (3) @(negedge ui_clk);
        check("t6_stale_ignored", para_valid, 1'b0);
        obs.delete();
        c0 = cmd_cnt; d0 = done_cnt;
        expect_job(32'h2040, 8);
        pulse_start(32'h2040, 8);
        wait_done(d0, 500);
        finish_job(d0);
        check("t6_cmds", cmd_cnt - c0, 1);
        check("t6_nwords", obs.size(), 8);
        check("t6_w0", obs[0], 16'h0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr3_para_rd.md
DDR3_PARA_RD -- requirements
Module: ddr3_para_rd

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning 128-bit lines buffered, counting lines in flight plus lines stored.
REQ-002 SHALL have parameter ADDR_STEP, default 8, meaning app_addr increment per 128-bit line.
REQ-003 SHALL have port ui_clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous reset, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a read job.
REQ-006 SHALL have port base_addr  in  32  DDR3 start address, sampled on start.
REQ-007 SHALL have port num_words  in  32  count of 16-bit parameters to deliver, sampled on start.
REQ-008 SHALL have port busy  out  1  high while a job is active.
REQ-009 SHALL have port done  out  1  one-cycle pulse after the last parameter is accepted.
REQ-010 SHALL have port app_rdy  in  1  memory controller accepts a command.
REQ-011 SHALL have port app_cmd_en  out  1  command valid.
REQ-012 SHALL have port app_cmd  out  3  command code; read is 3'b001.
REQ-013 SHALL have port app_addr  out  33  command address, zero-extended from the internal 32-bit address.
REQ-014 SHALL have port app_rd_data_valid  in  1  read data beat valid.
REQ-015 SHALL have port app_rd_data  in  128  read data beat.
REQ-016 SHALL have port para_valid  out  1  parameter output valid.
REQ-017 SHALL have port para_data  out  16  parameter output value.
REQ-018 SHALL have port para_ready  in  1  downstream consumer accepts the parameter.

Function
REQ-019 SHALL have states IDLE, ISSUE, DRAIN and FIN: IDLE->ISSUE on start; ISSUE->DRAIN when every line command has been accepted; DRAIN->FIN when the last word transfers; FIN->IDLE after one cycle.
REQ-020 SHALL compute lines = ceil(num_words/8) using a 33-bit intermediate, so num_words = 0xFFFFFFFF does not overflow.
REQ-021 SHALL treat a command as accepted only when app_cmd_en and app_rdy are both high in the same cycle; the address then advances by ADDR_STEP, wrapping modulo 2^32.
REQ-022 SHALL assert app_cmd_en only when lines in flight plus lines stored is less than FIFO_DEPTH; returned data is never dropped or back-pressured.
REQ-023 SHALL hold app_cmd_en and app_addr stable until the command is accepted.
REQ-024 SHALL write each app_rd_data_valid beat into the line FIFO in arrival order.
REQ-025 SHALL unpack each line LSB-halfword first: bits [15:0] first, bits [127:112] last.
REQ-026 SHALL transfer a word on para_valid and para_ready both high; para_data stays stable while para_valid is high and para_ready is low.
REQ-027 SHALL emit only num_words mod 8 halfwords from the final line when that remainder is nonzero, discarding the rest.
REQ-028 SHALL support one word per cycle with no bubble at a line boundary, provided the next line is already stored.
REQ-029 SHALL allow a FIFO write and a FIFO read in the same cycle, including when the FIFO is full or empty-then-written.
REQ-030 SHALL ignore start while busy is high.
REQ-031 SHALL, when num_words = 0, pulse done in the cycle after start and issue no commands.
REQ-032 SHALL keep busy high from the cycle after start until done, inclusive.

Reset
REQ-033 SHALL, on rst_n low, immediately clear to IDLE with busy, done, app_cmd_en, para_valid and app_addr at 0, app_cmd at 3'b001, the FIFO empty and all counters 0.
REQ-034 SHALL, after reset mid-job, ignore app_rd_data_valid beats until the next start.

Structure
REQ-035 SHALL place the command encodings (read 3'b001, write 3'b000), ADDR_STEP default and the state encoding in the shared package ddr3_para_pkg.
REQ-036 SHALL implement the 128-bit line buffer as sub-module para_line_fifo (synchronous, registered count, full/empty flags).

Verification
REQ-037 SHALL cover: base_addr = 0x100, num_words = 16, para_ready = 1, app_rdy = 1 -> commands at 0x100 and 0x108, 16 words LSB-first, done once.
REQ-038 SHALL cover: num_words = 19 -> 3 commands, 19 words, bits [127:48] of the third line discarded.
REQ-039 SHALL cover: para_ready = 0 for 200 cycles, num_words = 64 -> at most 4 commands issued, no data lost, all 64 words in order after release.
REQ-040 SHALL cover: app_rdy toggling every cycle -> app_addr held until accepted, no address skipped.
REQ-041 SHALL cover: num_words = 0 -> done the cycle after start, app_cmd_en never high.
REQ-042 SHALL cover: rst_n low mid-DRAIN, then start with num_words = 8 -> only new-job words delivered, stale beats ignored.
